// File: rtl/sdram_read_arbiter.sv
// Two-requester round-robin arbiter for a shared Avalon-MM SDRAM read port.
// One burst is outstanding at a time; read data is broadcast and qualified by grant.
module sdram_read_arbiter #(
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic [ADDR_W-1:0]  s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic               s_read,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid,
    output logic [1:0]         grant_o,
    output logic               busy_o,
    output logic               err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [BURST_W:0] CNT_ONE = {{BURST_W{1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [1:0]         grant_n;
    logic               ptr, ptr_n;
    logic               s_read_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [BURST_W-1:0] bc_n;
    logic [BURST_W:0]   cnt, cnt_n;
    logic               err_n;
    logic               pick_m1;
    logic [ADDR_W-1:0]  win_addr;
    logic [BURST_W-1:0] win_bc;

    // A lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        pick_m1  = m1_read && (!m0_read || ptr);
        win_addr = pick_m1 ? m1_address : m0_address;
        win_bc   = pick_m1 ? m1_burstcount : m0_burstcount;
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant_o;
        ptr_n    = ptr;
        s_read_n = s_read;
        addr_n   = s_address;
        bc_n     = s_burstcount;
        cnt_n    = cnt;
        err_n    = err_o;
        case (state)
            IDLE: begin
                if (s_readdatavalid) begin
                    err_n = 1'b1;
                end
                if (m0_read || m1_read) begin
                    grant_n  = pick_m1 ? 2'b10 : 2'b01;
                    addr_n   = win_addr;
                    bc_n     = win_bc;
                    s_read_n = 1'b1;
                    state_n  = ISSUE;
                    if (win_bc == '0) begin
                        cnt_n = CNT_ONE;
                        err_n = 1'b1;
                    end else begin
                        cnt_n = {1'b0, win_bc};
                    end
                end
            end
            ISSUE, DRAIN: begin
                if (state == ISSUE && !s_waitrequest) begin
                    s_read_n = 1'b0;
                    state_n  = DRAIN;
                end
                // The final beat may land in the acceptance cycle itself.
                if (s_readdatavalid) begin
                    if (cnt == '0) begin
                        err_n = 1'b1;
                    end else if (cnt == CNT_ONE) begin
                        cnt_n    = '0;
                        state_n  = IDLE;
                        grant_n  = 2'b00;
                        ptr_n    = ~ptr;
                        s_read_n = 1'b0;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                grant_n  = 2'b00;
                s_read_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_o      <= 2'b00;
            ptr          <= 1'b0;
            s_read       <= 1'b0;
            s_address    <= '0;
            s_burstcount <= '0;
            cnt          <= '0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_n;
            grant_o      <= grant_n;
            ptr          <= ptr_n;
            s_read       <= s_read_n;
            s_address    <= addr_n;
            s_burstcount <= bc_n;
            cnt          <= cnt_n;
            err_o        <= err_n;
        end
    end

    assign busy_o           = (state != IDLE);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & grant_o[0] & (state != IDLE);
    assign m1_readdatavalid = s_readdatavalid & grant_o[1] & (state != IDLE);
    assign m0_waitrequest   = ~(grant_o[0] & (state == ISSUE) & ~s_waitrequest);
    assign m1_waitrequest   = ~(grant_o[1] & (state == ISSUE) & ~s_waitrequest);

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: single burst, round-robin, backpressure,
// protocol errors and mid-burst reset, all against hand-computed expectations.
module tb_sdram_read_arbiter;

    localparam int ADDR_W  = 29;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 8;

    logic               clk;
    logic               rst;
    logic [ADDR_W-1:0]  m0_address, m1_address;
    logic [BURST_W-1:0] m0_burstcount, m1_burstcount;
    logic               m0_read, m1_read;
    logic               m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0]  m0_readdata, m1_readdata;
    logic               m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0]  s_address;
    logic [BURST_W-1:0] s_burstcount;
    logic               s_read;
    logic               s_waitrequest;
    logic [DATA_W-1:0]  s_readdata;
    logic               s_readdatavalid;
    logic [1:0]         grant_o;
    logic               busy_o;
    logic               err_o;

    int checks = 0;
    int errors = 0;

    sdram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst             = 1'b1;
        m0_read         = 1'b0;
        m1_read         = 1'b0;
        s_readdatavalid = 1'b0;
        s_waitrequest   = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_grant", 64'(grant_o), 64'h0);
        checkOutput("rst_busy", 64'(busy_o), 64'h0);
        checkOutput("rst_err", 64'(err_o), 64'h0);
        checkOutput("rst_s_read", 64'(s_read), 64'h0);
    endtask

    task automatic applyStimulus(input logic sel, input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] bc);
        if (sel) begin
            m1_address = addr; m1_burstcount = bc; m1_read = 1'b1;
        end else begin
            m0_address = addr; m0_burstcount = bc; m0_read = 1'b1;
        end
    endtask

    logic [DATA_W-1:0] pat;

    initial begin
        rst = 1'b1;
        m0_address = '0; m0_burstcount = '0; m0_read = 1'b0;
        m1_address = '0; m1_burstcount = '0; m1_read = 1'b0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        #1;
        checkOutput("rst_m0_wait", 64'(m0_waitrequest), 64'h1);
        checkOutput("rst_m1_wait", 64'(m1_waitrequest), 64'h1);
        applyReset();

        // Single burst of 8 from m0
        applyStimulus(1'b0, 29'h100, 8'd8);
        step();
        checkOutput("t1_s_read", 64'(s_read), 64'h1);
        checkOutput("t1_grant", 64'(grant_o), 64'h1);
        checkOutput("t1_addr", 64'(s_address), 64'h100);
        checkOutput("t1_bc", 64'(s_burstcount), 64'h8);
        checkOutput("t1_m0_wait", 64'(m0_waitrequest), 64'h0);
        checkOutput("t1_m1_wait", 64'(m1_waitrequest), 64'h1);
        checkOutput("t1_busy", 64'(busy_o), 64'h1);
        m0_read = 1'b0;
        step();
        checkOutput("t1_s_read_off", 64'(s_read), 64'h0);
        checkOutput("t1_m0_wait_drain", 64'(m0_waitrequest), 64'h1);
        for (int i = 0; i < 8; i++) begin
            pat = 64'hA5A5_0000_0000_0000 | 64'(i);
            s_readdata = pat;
            s_readdatavalid = 1'b1;
            #1;
            checkOutput("t1_m0_valid", 64'(m0_readdatavalid), 64'h1);
            checkOutput("t1_m1_valid", 64'(m1_readdatavalid), 64'h0);
            checkOutput("t1_m0_data", 64'(m0_readdata), pat);
            checkOutput("t1_m1_data", 64'(m1_readdata), pat);
            step();
            if (i < 7) checkOutput("t1_grant_hold", 64'(grant_o), 64'h1);
        end
        s_readdatavalid = 1'b0;
        #1;
        checkOutput("t1_grant_done", 64'(grant_o), 64'h0);
        checkOutput("t1_busy_done", 64'(busy_o), 64'h0);
        checkOutput("t1_err", 64'(err_o), 64'h0);

        // Both requesters continuously, burst 4 each: m0,m1,m0,m1
        applyReset();
        applyStimulus(1'b0, 29'h200, 8'd4);
        applyStimulus(1'b1, 29'h300, 8'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("t2_grant", 64'(grant_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            checkOutput("t2_addr", 64'(s_address), (k % 2 == 0) ? 64'h200 : 64'h300);
            checkOutput("t2_s_read", 64'(s_read), 64'h1);
            step();
            for (int b = 0; b < 4; b++) begin
                s_readdatavalid = 1'b1;
                #1;
                checkOutput("t2_m0_valid", 64'(m0_readdatavalid), (k % 2 == 0) ? 64'h1 : 64'h0);
                checkOutput("t2_m1_valid", 64'(m1_readdatavalid), (k % 2 == 0) ? 64'h0 : 64'h1);
                step();
            end
            s_readdatavalid = 1'b0;
            #1;
            checkOutput("t2_idle_gap", 64'(busy_o), 64'h0);
            checkOutput("t2_idle_grant", 64'(grant_o), 64'h0);
        end
        m0_read = 1'b0;
        m1_read = 1'b0;

        // Backpressure for 5 cycles
        applyReset();
        s_waitrequest = 1'b1;
        applyStimulus(1'b0, 29'h400, 8'd2);
        step();
        for (int c = 0; c < 5; c++) begin
            checkOutput("t3_s_read", 64'(s_read), 64'h1);
            checkOutput("t3_addr", 64'(s_address), 64'h400);
            checkOutput("t3_m0_wait", 64'(m0_waitrequest), 64'h1);
            step();
        end
        s_waitrequest = 1'b0;
        #1;
        checkOutput("t3_accept_wait", 64'(m0_waitrequest), 64'h0);
        checkOutput("t3_accept_s_read", 64'(s_read), 64'h1);
        m0_read = 1'b0;
        step();
        checkOutput("t3_s_read_off", 64'(s_read), 64'h0);
        s_readdatavalid = 1'b1;
        step();
        step();
        s_readdatavalid = 1'b0;
        #1;
        checkOutput("t3_done_busy", 64'(busy_o), 64'h0);

        // Zero burstcount behaves as one beat and flags an error
        applyReset();
        applyStimulus(1'b1, 29'h500, 8'd0);
        step();
        checkOutput("t4_err_zero_bc", 64'(err_o), 64'h1);
        checkOutput("t4_grant", 64'(grant_o), 64'h2);
        m1_read = 1'b0;
        step();
        s_readdatavalid = 1'b1;
        #1;
        checkOutput("t4_m1_valid", 64'(m1_readdatavalid), 64'h1);
        step();
        s_readdatavalid = 1'b0;
        #1;
        checkOutput("t4_one_beat_done", 64'(busy_o), 64'h0);

        // Stray beat in IDLE
        applyReset();
        s_readdatavalid = 1'b1;
        #1;
        checkOutput("t4_stray_m0", 64'(m0_readdatavalid), 64'h0);
        checkOutput("t4_stray_m1", 64'(m1_readdatavalid), 64'h0);
        step();
        s_readdatavalid = 1'b0;
        #1;
        checkOutput("t4_stray_err", 64'(err_o), 64'h1);

        // Reset after 3 of 8 beats abandons the burst
        applyReset();
        applyStimulus(1'b0, 29'h600, 8'd8);
        step();
        m0_read = 1'b0;
        step();
        s_readdatavalid = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_grant", 64'(grant_o), 64'h0);
        checkOutput("t5_rst_busy", 64'(busy_o), 64'h0);
        checkOutput("t5_rst_valid", 64'(m0_readdatavalid), 64'h0);
        checkOutput("t5_rst_wait", 64'(m0_waitrequest), 64'h1);
        checkOutput("t5_rst_err", 64'(err_o), 64'h0);
        s_readdatavalid = 1'b0;
        step();
        rst = 1'b0;
        s_readdatavalid = 1'b1;
        #1;
        for (int r = 0; r < 5; r++) begin
            checkOutput("t5_drop_valid", 64'(m0_readdatavalid), 64'h0);
            step();
            checkOutput("t5_err_after", 64'(err_o), 64'h1);
        end
        s_readdatavalid = 1'b0;
        #1;
        checkOutput("t5_idle", 64'(busy_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
